sfp_reset_seq: RTL

Reset sequencer downstream of the clock/MMCM stage. It drives the GT transceiver reset and waits for GT resetdone and SFP MMCM lock, then releases a deglitched core reset to the Ethernet logic. Timeouts trigger retries; repeated failure latches a fail flag. Runs on the free-running 50 MHz fabric clock.

---
 rtl/sfp_reset_pkg.sv | 22 ++
 rtl/sync_bit.sv | 20 ++
 rtl/sfp_reset_seq.sv | 135 +++++++++++++
 3 files changed

// File: rtl/sfp_reset_pkg.sv
// Shared constants for the SFP reset sequencer: state encoding and port widths.
package sfp_reset_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned RETRY_W = 4;
  localparam int unsigned LOL_W   = 16;

  localparam logic [STATE_W-1:0] ST_GT_RST = 3'd0;
  localparam logic [STATE_W-1:0] ST_WAIT   = 3'd1;
  localparam logic [STATE_W-1:0] ST_SETTLE = 3'd2;
  localparam logic [STATE_W-1:0] ST_RUN    = 3'd3;
  localparam logic [STATE_W-1:0] ST_FAIL   = 3'd4;

  // Largest of three counts; sizes the shared state timer.
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for a single asynchronous status bit; resets to 0.
module sync_bit #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) sync_q <= '0;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], i_d};
  end

  assign o_q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/sfp_reset_seq.sv
// GT/MMCM reset sequencer with timeout retries and a latched fail state.
// Optional loss-of-lock counter enabled by defining SFP_RST_LOL_CNT_EN.
module sfp_reset_seq
  import sfp_reset_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned HOLD_CYCLES   = 64,
  parameter int unsigned LOCK_TIMEOUT  = 500000,
  parameter int unsigned SETTLE_CYCLES = 256,
  parameter int unsigned MAX_RETRY     = 7
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_resetdone,
  input  logic               i_mmcm_locked,
  input  logic               i_retry_req,
  output logic               o_gt_reset,
  output logic               o_core_reset,
  output logic               o_ready,
  output logic               o_fail,
  output logic [RETRY_W-1:0] o_retry_cnt,
  output logic [STATE_W-1:0] o_state,
  output logic [LOL_W-1:0]   o_lol_cnt
);

  localparam int unsigned TMR_MAX = max3(HOLD_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES);
  localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  localparam logic [TMR_W-1:0]   HOLD_LAST   = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0]   LOCK_LAST   = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0]   SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRY);

  logic               resetdone_s;
  logic               locked_s;
  logic               ok;
  logic [STATE_W-1:0] state_d;
  logic [TMR_W-1:0]   timer_q;
  logic [TMR_W-1:0]   timer_d;
  logic [RETRY_W-1:0] retry_d;
  logic               gt_reset_d;
  logic               core_reset_d;
  logic               ready_d;
  logic               fail_d;

  sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_resetdone (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_d     (i_resetdone),
    .o_q     (resetdone_s)
  );

  sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_locked (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_d     (i_mmcm_locked),
    .o_q     (locked_s)
  );

  assign ok = resetdone_s & locked_s;

  // Next state, retry count and outputs decoded from the next state.
  always_comb begin
    state_d = o_state;
    retry_d = o_retry_cnt;
    case (o_state)
      ST_GT_RST: if (timer_q == HOLD_LAST) state_d = ST_WAIT;
      ST_WAIT: begin
        if (ok) begin
          state_d = ST_SETTLE;
        end else if (timer_q == LOCK_LAST) begin
          retry_d = o_retry_cnt + RETRY_W'(1);
          state_d = (retry_d == RETRY_MAX) ? ST_FAIL : ST_GT_RST;
        end
      end
      ST_SETTLE: begin
        if (!ok) begin
          state_d = ST_GT_RST;
        end else if (timer_q == SETTLE_LAST) begin
          state_d = ST_RUN;
          retry_d = '0;
        end
      end
      ST_RUN: if (!ok) state_d = ST_GT_RST;
      ST_FAIL: begin
        if (i_retry_req) begin
          state_d = ST_GT_RST;
          retry_d = '0;
        end
      end
      default: state_d = ST_GT_RST;
    endcase

    timer_d      = (state_d != o_state) ? '0 : timer_q + TMR_W'(1);
    gt_reset_d   = (state_d == ST_GT_RST) || (state_d == ST_FAIL);
    core_reset_d = (state_d != ST_RUN);
    ready_d      = (state_d == ST_RUN);
    fail_d       = (state_d == ST_FAIL);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_state      <= ST_GT_RST;
      timer_q      <= '0;
      o_retry_cnt  <= '0;
      o_gt_reset   <= 1'b1;
      o_core_reset <= 1'b1;
      o_ready      <= 1'b0;
      o_fail       <= 1'b0;
    end else begin
      o_state      <= state_d;
      timer_q      <= timer_d;
      o_retry_cnt  <= retry_d;
      o_gt_reset   <= gt_reset_d;
      o_core_reset <= core_reset_d;
      o_ready      <= ready_d;
      o_fail       <= fail_d;
    end
  end

`ifdef SFP_RST_LOL_CNT_EN
  logic lol_event;

  assign lol_event = (o_state == ST_RUN) && (state_d == ST_GT_RST);

  // Saturating loss-of-lock counter, cleared only by i_reset.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)                        o_lol_cnt <= '0;
    else if (lol_event && !(&o_lol_cnt)) o_lol_cnt <= o_lol_cnt + LOL_W'(1);
  end
`else
  assign o_lol_cnt = '0;
`endif

endmodule
